axi_dbg_master: RTL and testbench

// - Debug AXI initiator: converts a byte command stream (from a UART RX path) into single-beat
//   32-bit AXI reads/writes and returns response bytes (to a UART TX path).
// - Sits as an extra master port on the SoC AXI interconnect beside the core's instr/LSU masters.
// - Enables peek/poke and program loading of IMEM/DRAM/peripherals without the CPU.

---
 rtl/axi_dbg_master.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_dbg_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dbg_master.sv
// axi_dbg_master: debug AXI initiator driven by a byte command stream.
//
// Commands (bytes, LSB first):
//   CMD_WR a0 a1 a2 a3 d0 d1 d2 d3 -> single-beat 32-bit write, reply {6'b0,bresp}
//   CMD_RD a0 a1 a2 a3             -> single-beat 32-bit read,  reply r0 r1 r2 r3 {6'b0,rresp}
//   anything else                  -> reply 8'hEE, no AXI traffic
// Optional macro DBG_AUTOINC_EN: opcodes 'w' (8'h77) and 'r' (8'h72) skip the
// address bytes and target last_addr+4 (last_addr = address of the previous
// completed transaction, 0 after reset).
//
// Ports:
//   clk, arst                 clock, async active-low reset
//   rx_data_i/valid_i/ready_o command byte stream in
//   tx_data_o/valid_o/ready_i response byte stream out
//   axi_mosi_o / axi_miso_i   AXI4 master channels (packed structs below)
//   busy_o                    high whenever the FSM is not idle

typedef struct packed {
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic [3:0]  awregion;
  logic        awvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic [3:0]  arregion;
  logic        arvalid;
  logic        rready;
} s_axi_mosi_t;

typedef struct packed {
  logic        awready;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
} s_axi_miso_t;

module axi_dbg_master #(
  parameter int         AXI_ID = 0,
  parameter logic [7:0] CMD_WR = 8'h57,
  parameter logic [7:0] CMD_RD = 8'h52
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output s_axi_mosi_t axi_mosi_o,
  input  s_axi_miso_t axi_miso_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, AW_W, B, AR, R, RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [31:0] addr, data;
  logic [1:0]  resp;
  logic        is_wr, is_bad;
  logic        aw_done, w_done;
  logic        live;   // keeps rx_ready_o low while reset is asserted

`ifdef DBG_AUTOINC_EN
  logic [31:0] last_addr;
`endif

  logic rx_fire, tx_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic op_wr, op_rd, op_wi, op_ri, op_bad, resp_last;

  assign rx_fire = rx_valid_i && rx_ready_o;
  assign tx_fire = tx_valid_o && tx_ready_i;
  assign aw_fire = axi_mosi_o.awvalid && axi_miso_i.awready;
  assign w_fire  = axi_mosi_o.wvalid  && axi_miso_i.wready;
  assign b_fire  = axi_mosi_o.bready  && axi_miso_i.bvalid;
  assign ar_fire = axi_mosi_o.arvalid && axi_miso_i.arready;
  assign r_fire  = axi_mosi_o.rready  && axi_miso_i.rvalid;

  // IDs and rlast are deliberately ignored
  logic unused_miso;
  assign unused_miso = ^{axi_miso_i.bid, axi_miso_i.rid, axi_miso_i.rlast};

  always_comb begin
    op_wr = (rx_data_i == CMD_WR);
    op_rd = (rx_data_i == CMD_RD);
    op_wi = 1'b0;
    op_ri = 1'b0;
`ifdef DBG_AUTOINC_EN
    op_wi = (rx_data_i == 8'h77);
    op_ri = (rx_data_i == 8'h72);
`endif
    op_bad = !(op_wr || op_rd || op_wi || op_ri);
  end

  // write / error replies are one status byte; reads are 4 data bytes + status
  assign resp_last = (is_wr || is_bad) ? (cnt == 3'd0) : (cnt == 3'd4);

  // state register
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rx_fire) begin
        if (op_wr || op_rd) state_nxt = ADDR;
        else if (op_wi)     state_nxt = DATA;
        else if (op_ri)     state_nxt = AR;
        else                state_nxt = RESP;
      end
      ADDR: if (rx_fire && cnt == 3'd3) state_nxt = is_wr ? DATA : AR;
      DATA: if (rx_fire && cnt == 3'd3) state_nxt = AW_W;
      AW_W: if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = B;
      B:    if (b_fire)  state_nxt = RESP;
      AR:   if (ar_fire) state_nxt = R;
      R:    if (r_fire)  state_nxt = RESP;
      RESP: if (tx_fire && resp_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      live    <= 1'b0;
      cnt     <= '0;
      addr    <= '0;
      data    <= '0;
      resp    <= '0;
      is_wr   <= 1'b0;
      is_bad  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifdef DBG_AUTOINC_EN
      last_addr <= '0;
`endif
    end else begin
      live <= 1'b1;
      // byte counter restarts on every state change
      if (state_nxt != state)       cnt <= '0;
      else if (rx_fire || tx_fire)  cnt <= cnt + 3'd1;
      case (state)
        IDLE: if (rx_fire) begin
          is_wr  <= op_wr || op_wi;
          is_bad <= op_bad;
`ifdef DBG_AUTOINC_EN
          if (op_wi || op_ri) addr <= last_addr + 32'd4;
`endif
        end
        ADDR: if (rx_fire) addr <= {rx_data_i, addr[31:8]};
        DATA: if (rx_fire) data <= {rx_data_i, data[31:8]};
        AW_W: begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
        end
        B: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (b_fire) begin
            resp <= axi_miso_i.bresp;
`ifdef DBG_AUTOINC_EN
            last_addr <= addr;
`endif
          end
        end
        R: if (r_fire) begin
          data <= axi_miso_i.rdata;
          resp <= axi_miso_i.rresp;
`ifdef DBG_AUTOINC_EN
          last_addr <= addr;
`endif
        end
        default: ;
      endcase
    end
  end

  // outputs (Moore: derived only from registered state)
  always_comb begin
    rx_ready_o = live && (state == IDLE || state == ADDR || state == DATA);
    tx_valid_o = (state == RESP);
    busy_o     = (state != IDLE);
    tx_data_o  = 8'h00;
    if (state == RESP) begin
      if (is_bad)                     tx_data_o = 8'hEE;
      else if (!is_wr && cnt < 3'd4)  tx_data_o = data[{cnt[1:0], 3'b000} +: 8];
      else                            tx_data_o = {6'b0, resp};
    end

    axi_mosi_o          = '0;
    axi_mosi_o.awid     = 4'(AXI_ID);
    axi_mosi_o.awaddr   = addr;
    axi_mosi_o.awsize   = 3'b010;
    axi_mosi_o.awburst  = 2'b01;
    axi_mosi_o.awvalid  = (state == AW_W) && !aw_done;
    axi_mosi_o.wdata    = data;
    axi_mosi_o.wstrb    = 4'hF;
    axi_mosi_o.wlast    = 1'b1;
    axi_mosi_o.wvalid   = (state == AW_W) && !w_done;
    axi_mosi_o.bready   = (state == B);
    axi_mosi_o.arid     = 4'(AXI_ID);
    axi_mosi_o.araddr   = addr;
    axi_mosi_o.arsize   = 3'b010;
    axi_mosi_o.arburst  = 2'b01;
    axi_mosi_o.arvalid  = (state == AR);
    axi_mosi_o.rready   = (state == R);
  end

endmodule

// File: tb/tb_axi_dbg_master.sv
// Scoreboard bench for axi_dbg_master: stimulus pushes expected AXI requests,
// slave responses and reply bytes into queues; a negedge monitor/slave pops
// and compares whenever a handshake is about to happen.
module tb_axi_dbg_master;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso = '0;
  logic        busy;

  axi_dbg_master dut (
    .clk(clk), .arst(arst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .axi_mosi_o(mosi), .axi_miso_i(miso), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int aw_dly, w_dly, ar_dly, rsp_dly;
  } plan_t;

  logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
  logic [7:0]  exp_tx[$];
  plan_t       plan_q[$];
  logic [31:0] last_addr = 32'h0;   // reference model state
  bit          hold_tx = 1'b0;

  // ---------------- slave + monitor (all decisions at negedge) ------------
  plan_t cur;
  bit    have_plan, aw_ok, w_ok, ar_ok, b_pend, r_pend;
  int    aw_cnt, w_cnt, ar_cnt, rsp_cnt;
  bit    prev_awv, prev_awf, prev_wv, prev_wf, prev_arv, prev_arf, prev_txv, prev_txr;
  logic [7:0] prev_txd;

  always @(negedge clk) begin
    if (!arst) begin
      miso = '0; tx_ready = 1'b0;
      have_plan = 0; aw_ok = 0; w_ok = 0; ar_ok = 0; b_pend = 0; r_pend = 0;
      prev_awv = 0; prev_wv = 0; prev_arv = 0; prev_txv = 0;
      prev_awf = 0; prev_wf = 0; prev_arf = 0; prev_txr = 0;
    end else begin
      // retire B/R handshakes that happened on the last posedge
      if (b_pend || r_pend) begin
        chk("tx_valid_latency", {31'b0, tx_valid}, 32'd1);
        miso.bvalid = 1'b0; miso.rvalid = 1'b0;
        b_pend = 0; r_pend = 0; have_plan = 0;
      end
      // valid must not drop before its handshake
      if (prev_awv && !prev_awf) chk("awvalid_hold", {31'b0, mosi.awvalid}, 32'd1);
      if (prev_wv  && !prev_wf)  chk("wvalid_hold",  {31'b0, mosi.wvalid},  32'd1);
      if (prev_arv && !prev_arf) chk("arvalid_hold", {31'b0, mosi.arvalid}, 32'd1);

      if (!have_plan && (mosi.awvalid || mosi.wvalid || mosi.arvalid)) begin
        if (plan_q.size() == 0) chk("unexpected_axi", 32'd1, 32'd0);
        else begin
          cur = plan_q.pop_front();
          have_plan = 1; aw_ok = 0; w_ok = 0; ar_ok = 0;
          aw_cnt = 0; w_cnt = 0; ar_cnt = 0; rsp_cnt = 0;
        end
      end

      miso.awready = 0; miso.wready = 0; miso.arready = 0;
      if (have_plan) begin
        // response channels first so B/R never coincide with the request handshake
        if (aw_ok && w_ok && !miso.bvalid) begin
          if (rsp_cnt >= cur.rsp_dly) begin miso.bvalid = 1; miso.bresp = cur.resp; end
          else rsp_cnt++;
        end
        if (ar_ok && !miso.rvalid) begin
          if (rsp_cnt >= cur.rsp_dly) begin
            miso.rvalid = 1; miso.rdata = cur.rdata; miso.rresp = cur.resp;
            miso.rlast = 1'($urandom % 2);
          end else rsp_cnt++;
        end
        if (miso.bvalid && mosi.bready) b_pend = 1;
        if (miso.rvalid && mosi.rready) r_pend = 1;

        miso.awready = mosi.awvalid && (aw_cnt >= cur.aw_dly);
        miso.wready  = mosi.wvalid  && (w_cnt  >= cur.w_dly);
        miso.arready = mosi.arvalid && (ar_cnt >= cur.ar_dly);
        if (mosi.awvalid) aw_cnt++;
        if (mosi.wvalid)  w_cnt++;
        if (mosi.arvalid) ar_cnt++;

        if (mosi.awvalid && miso.awready) begin
          aw_ok = 1;
          chk("awvalid_cycles", aw_cnt, cur.aw_dly + 1);
          chk("aw_fields", {mosi.awlen, 1'b0, mosi.awsize, 2'b0, mosi.awburst, 12'b0, mosi.awid},
                           {8'h00, 1'b0, 3'b010, 2'b0, 2'b01, 12'b0, 4'h0});
          if (exp_aw.size() == 0) chk("aw_unexpected", mosi.awaddr, 32'hX);
          else chk("awaddr", mosi.awaddr, exp_aw.pop_front());
        end
        if (mosi.wvalid && miso.wready) begin
          w_ok = 1;
          chk("wvalid_cycles", w_cnt, cur.w_dly + 1);
          chk("w_strb_last", {27'b0, mosi.wstrb, mosi.wlast}, {27'b0, 4'hF, 1'b1});
          if (exp_w.size() == 0) chk("w_unexpected", mosi.wdata, 32'hX);
          else chk("wdata", mosi.wdata, exp_w.pop_front());
        end
        if (mosi.arvalid && miso.arready) begin
          ar_ok = 1;
          chk("ar_fields", {mosi.arlen, 1'b0, mosi.arsize, 2'b0, mosi.arburst, 12'b0, mosi.arid},
                           {8'h00, 1'b0, 3'b010, 2'b0, 2'b01, 12'b0, 4'h0});
          if (exp_ar.size() == 0) chk("ar_unexpected", mosi.araddr, 32'hX);
          else chk("araddr", mosi.araddr, exp_ar.pop_front());
        end
      end
      prev_awv = mosi.awvalid; prev_awf = mosi.awvalid && miso.awready;
      prev_wv  = mosi.wvalid;  prev_wf  = mosi.wvalid  && miso.wready;
      prev_arv = mosi.arvalid; prev_arf = mosi.arvalid && miso.arready;

      // response byte stream
      if (prev_txv && !prev_txr) begin
        chk("tx_valid_stable", {31'b0, tx_valid}, 32'd1);
        chk("tx_data_stable", {24'b0, tx_data}, {24'b0, prev_txd});
      end
      tx_ready = hold_tx ? 1'b0 : ($urandom % 4 != 0);
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) chk("tx_unexpected", {24'b0, tx_data}, 32'hX);
        else chk("tx_byte", {24'b0, tx_data}, {24'b0, exp_tx.pop_front()});
      end
      prev_txv = tx_valid; prev_txr = tx_ready; prev_txd = tx_data;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1; rx_data = b;
    while (!rx_ready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("rx_ready_timeout", 32'd1, 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Reference model: decide the transaction from the opcode, queue expectations, send bytes.
  task automatic do_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] rs, input logic [31:0] rd,
                        input int awd, input int wd, input int ard, input int rsd);
    bit wr, rdc, ai_w, ai_r;
    logic [31:0] ea;
    plan_t p;
    wr = (op == 8'h57); rdc = (op == 8'h52); ai_w = 0; ai_r = 0;
`ifdef DBG_AUTOINC_EN
    ai_w = (op == 8'h77); ai_r = (op == 8'h72);
`endif
    ea = (ai_w || ai_r) ? last_addr + 32'd4 : a;
    p.resp = rs; p.rdata = rd; p.aw_dly = awd; p.w_dly = wd; p.ar_dly = ard; p.rsp_dly = rsd;
    if (wr || ai_w) begin
      exp_aw.push_back(ea); exp_w.push_back(d);
      exp_tx.push_back({6'b0, rs}); plan_q.push_back(p); last_addr = ea;
    end else if (rdc || ai_r) begin
      exp_ar.push_back(ea);
      for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
      exp_tx.push_back({6'b0, rs}); plan_q.push_back(p); last_addr = ea;
    end else exp_tx.push_back(8'hEE);

    send_byte(op);
    if (wr || rdc) for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    if (wr || ai_w) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    // first AXI valid must be up the cycle after the last command byte
    if (wr || ai_w) chk("aw_w_latency", {30'b0, mosi.awvalid, mosi.wvalid}, 32'd3);
    else if (rdc || ai_r) chk("ar_latency", {31'b0, mosi.arvalid}, 32'd1);
    else chk("bad_no_axi", {29'b0, mosi.awvalid, mosi.wvalid, mosi.arvalid}, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_tx.size() != 0 || busy) && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [7:0]  op;
    logic [31:0] v;
    int n;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", {tx_data, 5'b0, tx_valid, rx_ready, busy}, 32'h0);
    chk("rst_axi_valid", {27'b0, mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid, mosi.rready}, 32'h0);
    arst = 1'b1;
    @(negedge clk);

    // directed cases
    do_cmd(8'h57, 32'h1000_0000, 32'hDEAD_BEEF, 2'b00, 32'h0, 0, 0, 0, 0);
    do_cmd(8'h52, 32'h1000_0004, 32'h0, 2'b00, 32'h1234_5678, 0, 0, 1, 0);
    do_cmd(8'h57, 32'h2000_0010, 32'hCAFE_F00D, 2'b00, 32'h0, 5, 0, 0, 2);  // skewed AW
    do_cmd(8'h52, 32'hF000_0000, 32'h0, 2'b11, 32'h89AB_CDEF, 0, 0, 0, 3);  // DECERR
    do_cmd(8'h41, 32'h0, 32'h0, 2'b00, 32'h0, 0, 0, 0, 0);                  // bad opcode
    do_cmd(8'h57, 32'h0000_0003, 32'h0102_0304, 2'b10, 32'h0, 1, 3, 0, 0);  // misaligned, SLVERR
    drain();

    // backpressure: response held 10 cycles, monitor checks stability
    hold_tx = 1'b1;
    do_cmd(8'h52, 32'h3000_0000, 32'h0, 2'b00, 32'hA5A5_5A5A, 0, 0, 0, 0);
    n = 0;
    while (!tx_valid && n < 200) begin @(negedge clk); n++; end
    chk("bp_tx_valid", {31'b0, tx_valid}, 32'd1);
    v = {24'b0, tx_data};
    repeat (10) @(negedge clk);
    chk("bp_tx_data_held", {24'b0, tx_data}, v);
    hold_tx = 1'b0;
    drain();

    // reset while arvalid is high
    do_cmd(8'h52, 32'h4000_0000, 32'h0, 2'b00, 32'h1111_2222, 0, 0, 30, 0);
    repeat (2) @(negedge clk);
    chk("pre_rst_busy_arvalid", {30'b0, busy, mosi.arvalid}, 32'd3);
    #2 arst = 1'b0;
    #1 chk("rst_abort", {29'b0, busy, mosi.arvalid, tx_valid}, 32'd0);
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_tx.delete(); plan_q.delete();
    last_addr = 32'h0;
    repeat (2) @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    do_cmd(8'h52, 32'h4000_0008, 32'h0, 2'b00, 32'h3333_4444, 0, 0, 0, 0);
    drain();

    // auto-increment read (0xEE when the feature is not built)
    do_cmd(8'h52, 32'hA000_0000, 32'h0, 2'b00, 32'h5555_6666, 0, 0, 0, 0);
    do_cmd(8'h72, 32'h0, 32'h0, 2'b00, 32'h7777_8888, 0, 0, 0, 0);
    do_cmd(8'h77, 32'h0, 32'hBEEF_0001, 2'b00, 32'h0, 0, 2, 0, 0);
    drain();

    // randomized commands
    for (int i = 0; i < 40; i++) begin
      case ($urandom % 5)
        0: op = 8'h57;
        1: op = 8'h52;
        2: op = 8'h77;
        3: op = 8'h72;
        default: begin
          op = 8'($urandom);
          if (op == 8'h57 || op == 8'h52 || op == 8'h77 || op == 8'h72) op = 8'h00;
        end
      endcase
      do_cmd(op, $urandom, $urandom, 2'($urandom), $urandom,
             $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 4);
    end
    drain();

    chk("left_exp_tx", exp_tx.size(), 32'd0);
    chk("left_exp_aw_w_ar", exp_aw.size() + exp_w.size() + exp_ar.size(), 32'd0);
    chk("left_plan", plan_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
